imem_bank: RTL and testbench
============================

Name: imem_bank

Overview:
- Parametrised successor to the single-cycle core's instruction memory.
- Holds DEPTH 32-bit instructions and serves a registered fetch port with a ready/valid handshake and fault reporting.
- Clears itself to NOP after reset using a sequenced sweep.
- Accepts program loads through a streaming write port with an auto-incrementing address.
- Decodes the fetched word into fields, a one-hot type and a sign-extended immediate.
- Sits between the PC/fetch logic and the decode/execute stages; the load port is driven from the logic-analyser/management interface.

Parameters:
- DEPTH, 16, number of instruction words (power of two, >=2)
- AW, $clog2(DEPTH), word-index width
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- NOP_WORD, 32'h0000_0013, fill value (addi x0,x0,0)

Ports:
- clk, in, 1, clock
- rst_n, in, 1, synchronous active-low reset
- fetch_req, in, 1, fetch request
- fetch_pc, in, 32, byte address to fetch
- fetch_ready, out, 1, bank can accept a fetch
- fetch_valid, out, 1, instr/decode outputs valid this cycle
- fetch_fault, out, 1, misaligned, out-of-range (or parity) fetch
- instr, out, 32, fetched word
- instruction_type, out, 6, one-hot {j,u,b,s,i,r}
- opcode, out, 7, instr[6:0]
- rd, out, 5, instr[11:7]
- rs1, out, 5, instr[19:15]
- rs2, out, 5, instr[24:20]
- funct3, out, 3, instr[14:12]
- funct7, out, 7, instr[31:25]
- immediate, out, 32, sign-extended immediate
- prog_start, in, 1, pulse: begin a load
- prog_addr, in, AW, start word index, sampled with prog_start
- prog_valid, in, 1, load beat valid
- prog_data, in, 32, load beat data
- prog_last, in, 1, final beat of the load
- prog_ready, out, 1, load beat accepted when prog_valid is also high
- init_done, out, 1, clear sweep finished
- dbg_sel, in, AW, debug read index
- dbg_rdata, out, 32, combinational read of mem[dbg_sel]

Behaviour:
- Reset is synchronous and active-low on rst_n; clock is clk. Memory contents are not reset directly.
- Reset values: FSM=CLEAR, clear counter=0, fetch_valid=0, fetch_fault=0, instr=NOP_WORD, prog_ready=0, init_done=0, fetch_ready=0.
- FSM states: CLEAR, RUN, LOAD.
- CLEAR: writes NOP_WORD to mem[cnt] each cycle, cnt++. After the write of index DEPTH-1: go to RUN and set init_done=1. init_done stays 1 until the next reset. The sweep takes exactly DEPTH cycles.
- RUN:
  - fetch_ready=1.
  - prog_start=1 → LOAD; load pointer <= prog_addr. The same cycle's fetch handshake is still honoured.
- LOAD:
  - fetch_ready=0, prog_ready=1.
  - On prog_valid&&prog_ready: mem[ptr] <= prog_data; ptr <= ptr+1, wrapping modulo DEPTH.
  - If prog_last is on an accepted beat → RUN next cycle.
  - prog_start is ignored in LOAD and CLEAR.
- Fetch: on fetch_req&&fetch_ready the request is sampled; exactly 1 cycle later fetch_valid=1 with the outputs registered.
  - Index = (fetch_pc-BASE_ADDR)>>2.
  - Fault if fetch_pc[1:0]!=0 or index>=DEPTH: fetch_fault=1, instr=NOP_WORD.
  - Otherwise instr=mem[index], fetch_fault=0.
  - With no handshake, fetch_valid=0 next cycle and instr holds its last value.
- A fetch accepted in the cycle prog_start arrives returns the pre-load word.
- A fetch of a word written in the same cycle returns the old word (read-before-write).
- Decode is combinational from the registered instr:
  - R-type: opcode 0110011.
  - I-type: opcodes 0010011, 0000011, 1100111, 1110011.
  - S-type: 0100011.
  - B-type: 1100011.
  - U-type: 0110111, 0010111.
  - J-type: 1101111.
  - Unknown opcode: type=0, immediate=0.
- Immediates are the full 32 bits (I/S/B/J sign-extended from bit 31; U = instr[31:12]<<12). R-type and unknown give immediate=0.
- Reset during LOAD or CLEAR: the FSM restarts in CLEAR; partial loads are lost.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each word is stored as 33 bits with even parity computed on write (clear, load).
  - Parity is checked on fetch; a mismatch sets fetch_fault=1 and instr=NOP_WORD.
  - Adds output parity_err (1 bit), sticky until reset.
- Undefined: 32-bit storage, no parity_err port, no parity check.

Decomposition:
- Package imem_pkg:
  - instr_type_t (6-bit one-hot) and opcode localparams.
  - NOP_WORD default.
  - FSM state enum {CLEAR, RUN, LOAD}.
  - Function imm_gen(instr, type).
- Sub-module imem_decode: purely combinational field/type/immediate decode of instr. It is reusable by the next pipelined core.

Test Plan:
- Reset, hold fetch_req=1, pc=0 → fetch_ready=0 for 16 cycles, init_done rises at cycle 16. First fetch returns instr=32'h00000013 with type=000010 and immediate=0.
- Load at prog_addr=3 with 3 beats: 32'h03C00093, 32'h00002023, 32'h00002103 (prog_last on beat 3). Fetch pc=12/16/20 → exact words returned. pc=12 decodes rd=1 and immediate=60.
- Load at prog_addr=15 with 2 beats → mem[15] and mem[0] written (wrap). Fetch pc=0 returns beat 2.
- Fetch pc=2 → fetch_fault=1, instr=NOP. Fetch pc=64 (DEPTH=16) → fetch_fault=1.
- Fetch pc=60 holding jal x0,-60 (32'hFC5FF06F) → type=100000, immediate=32'hFFFFFFC4.
- Assert prog_start and fetch_req in the same RUN cycle → the fetch returns the old word and fetch_ready=0 the next cycle. Then assert reset mid-LOAD → CLEAR restarts and all words read NOP afterwards.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and decode helpers for the instruction memory bank and its decoder.
// Nothing in this package depends on IMEM_PARITY_EN.
package imem_pkg;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // One-hot {j,u,b,s,i,r}; all-zero marks an unknown opcode.
    typedef enum logic [5:0] {
        TYPE_NONE = 6'b000000,
        TYPE_R    = 6'b000001,
        TYPE_I    = 6'b000010,
        TYPE_S    = 6'b000100,
        TYPE_B    = 6'b001000,
        TYPE_U    = 6'b010000,
        TYPE_J    = 6'b100000
    } instr_type_t;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        LOAD
    } imem_state_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input instr_type_t itype);
        logic [31:0] imm;
        imm = '0;
        case (itype)
            TYPE_I:  imm = {{20{instr[31]}}, instr[31:20]};
            TYPE_S:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            TYPE_B:  imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            TYPE_U:  imm = {instr[31:12], 12'b0};
            TYPE_J:  imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imem_decode.sv
// Combinational field, one-hot type and immediate decode of a 32-bit RV32 instruction.
module imem_decode
    import imem_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [5:0]  instruction_type_o,
    output logic [6:0]  opcode_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output logic [31:0] immediate_o
);

    instr_type_t itype;

    always_comb begin
        itype = TYPE_NONE;
        case (instr_i[6:0])
            OP_R:                                 itype = TYPE_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  itype = TYPE_I;
            OP_STORE:                             itype = TYPE_S;
            OP_BRANCH:                            itype = TYPE_B;
            OP_LUI, OP_AUIPC:                     itype = TYPE_U;
            OP_JAL:                               itype = TYPE_J;
            default:                              itype = TYPE_NONE;
        endcase
    end

    assign instruction_type_o = itype;
    assign opcode_o           = instr_i[6:0];
    assign rd_o               = instr_i[11:7];
    assign rs1_o              = instr_i[19:15];
    assign rs2_o              = instr_i[24:20];
    assign funct3_o           = instr_i[14:12];
    assign funct7_o           = instr_i[31:25];
    assign immediate_o        = imm_gen(instr_i, itype);

endmodule

// File: rtl/imem_bank.sv
// Instruction memory bank: NOP clear sweep, streaming program load, registered fetch with fault.
// Define IMEM_PARITY_EN for 33-bit even-parity storage and the sticky parity_err output.
module imem_bank
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AW        = $clog2(DEPTH),
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_pc,
    output logic          fetch_ready,
    output logic          fetch_valid,
    output logic          fetch_fault,
    output logic [31:0]   instr,
    output logic [5:0]    instruction_type,
    output logic [6:0]    opcode,
    output logic [4:0]    rd,
    output logic [4:0]    rs1,
    output logic [4:0]    rs2,
    output logic [2:0]    funct3,
    output logic [6:0]    funct7,
    output logic [31:0]   immediate,
    input  logic          prog_start,
    input  logic [AW-1:0] prog_addr,
    input  logic          prog_valid,
    input  logic [31:0]   prog_data,
    input  logic          prog_last,
    output logic          prog_ready,
    output logic          init_done,
    input  logic [AW-1:0] dbg_sel,
    output logic [31:0]   dbg_rdata
`ifdef IMEM_PARITY_EN
    ,
    output logic          parity_err
`endif
);

`ifdef IMEM_PARITY_EN
    localparam int unsigned MW = 33;
`else
    localparam int unsigned MW = 32;
`endif

    logic [MW-1:0] mem [DEPTH];

    imem_state_t   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          init_q, init_d;
    logic          valid_q;
    logic          fault_q;
    logic [31:0]   instr_q;

    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic [MW-1:0] wword;

    logic          fetch_hs;
    logic [29:0]   word_idx;
    logic          addr_bad;
    logic [MW-1:0] rd_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        init_d  = init_q;
        we      = 1'b0;
        waddr   = cnt_q;
        wdata   = NOP_WORD;
        case (state_q)
            CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = NOP_WORD;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                    init_d  = 1'b1;
                end
            end
            RUN: begin
                if (prog_start) begin
                    state_d = LOAD;
                    ptr_d   = prog_addr;
                end
            end
            LOAD: begin
                if (prog_valid) begin
                    we    = 1'b1;
                    waddr = ptr_q;
                    wdata = prog_data;
                    ptr_d = ptr_q + 1'b1;
                    if (prog_last) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign fetch_ready = (state_q == RUN);
    assign prog_ready  = (state_q == LOAD);
    assign init_done   = init_q;

`ifdef IMEM_PARITY_EN
    assign wword = {^wdata, wdata};
`else
    assign wword = wdata;
`endif

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wword;
        end
    end

    // BASE_ADDR is word aligned, so the index is the difference of the word fields.
    assign word_idx = fetch_pc[31:2] - BASE_ADDR[31:2];
    assign addr_bad = (fetch_pc[1:0] != 2'b00) || ({2'b00, word_idx} >= 32'(DEPTH));
    assign rd_word  = mem[word_idx[AW-1:0]];
    assign fetch_hs = fetch_req && fetch_ready;

`ifdef IMEM_PARITY_EN
    logic perr_q;
    logic par_bad;
    assign par_bad    = ^rd_word;
    assign parity_err = perr_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ptr_q   <= '0;
            init_q  <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            instr_q <= NOP_WORD;
`ifdef IMEM_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            init_q  <= init_d;
            valid_q <= fetch_hs;
            if (fetch_hs) begin
                if (addr_bad) begin
                    fault_q <= 1'b1;
                    instr_q <= NOP_WORD;
`ifdef IMEM_PARITY_EN
                end else if (par_bad) begin
                    fault_q <= 1'b1;
                    instr_q <= NOP_WORD;
                    perr_q  <= 1'b1;
`endif
                end else begin
                    fault_q <= 1'b0;
                    instr_q <= rd_word[31:0];
                end
            end else begin
                fault_q <= 1'b0;
            end
        end
    end

    assign fetch_valid = valid_q;
    assign fetch_fault = fault_q;
    assign instr       = instr_q;
    assign dbg_rdata   = mem[dbg_sel][31:0];

    imem_decode u_decode (
        .instr_i            (instr_q),
        .instruction_type_o (instruction_type),
        .opcode_o           (opcode),
        .rd_o               (rd),
        .rs1_o              (rs1),
        .rs2_o              (rs2),
        .funct3_o           (funct3),
        .funct7_o           (funct7),
        .immediate_o        (immediate)
    );

endmodule

// File: tb/tb_imem_bank.sv
// Randomized self-checking bench for imem_bank against an array-based memory model.
module tb_imem_bank;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk;
    logic          rst_n;
    logic          fetch_req;
    logic [31:0]   fetch_pc;
    logic          fetch_ready;
    logic          fetch_valid;
    logic          fetch_fault;
    logic [31:0]   instr;
    logic [5:0]    instruction_type;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [31:0]   immediate;
    logic          prog_start;
    logic [AW-1:0] prog_addr;
    logic          prog_valid;
    logic [31:0]   prog_data;
    logic          prog_last;
    logic          prog_ready;
    logic          init_done;
    logic [AW-1:0] dbg_sel;
    logic [31:0]   dbg_rdata;
`ifdef IMEM_PARITY_EN
    logic          parity_err;
`endif

    imem_bank #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (32'h0000_0000),
        .NOP_WORD  (NOP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_req        (fetch_req),
        .fetch_pc         (fetch_pc),
        .fetch_ready      (fetch_ready),
        .fetch_valid      (fetch_valid),
        .fetch_fault      (fetch_fault),
        .instr            (instr),
        .instruction_type (instruction_type),
        .opcode           (opcode),
        .rd               (rd),
        .rs1              (rs1),
        .rs2              (rs2),
        .funct3           (funct3),
        .funct7           (funct7),
        .immediate        (immediate),
        .prog_start       (prog_start),
        .prog_addr        (prog_addr),
        .prog_valid       (prog_valid),
        .prog_data        (prog_data),
        .prog_last        (prog_last),
        .prog_ready       (prog_ready),
        .init_done        (init_done),
        .dbg_sel          (dbg_sel),
        .dbg_rdata        (dbg_rdata)
`ifdef IMEM_PARITY_EN
        ,
        .parity_err       (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] load_buf [DEPTH];
    logic [31:0] last_instr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] ref_type(input logic [31:0] w);
        case (w[6:0])
            7'h33:                      return 6'b000001;
            7'h13, 7'h03, 7'h67, 7'h73: return 6'b000010;
            7'h23:                      return 6'b000100;
            7'h63:                      return 6'b001000;
            7'h37, 7'h17:               return 6'b010000;
            7'h6F:                      return 6'b100000;
            default:                    return 6'b000000;
        endcase
    endfunction

    // Immediates via arithmetic shifts of the signed word rather than bit replication.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic signed [31:0] s;
        logic [31:0]        sgn;
        s   = w;
        sgn = s >>> 31;
        case (ref_type(w))
            6'b000010: return s >>> 20;
            6'b000100: return ((s >>> 25) << 5) + {27'b0, w[11:7]};
            6'b001000: return (sgn << 12) + ({31'b0, w[7]} << 11) + ({26'b0, w[30:25]} << 5)
                              + ({28'b0, w[11:8]} << 1);
            6'b010000: return w & 32'hFFFF_F000;
            6'b100000: return (sgn << 20) + ({24'b0, w[19:12]} << 12) + ({31'b0, w[20]} << 11)
                              + ({22'b0, w[30:21]} << 1);
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom();
        case ($urandom_range(0, 10))
            0:       op = 7'h33;
            1:       op = 7'h13;
            2:       op = 7'h03;
            3:       op = 7'h67;
            4:       op = 7'h73;
            5:       op = 7'h23;
            6:       op = 7'h63;
            7:       op = 7'h37;
            8:       op = 7'h17;
            9:       op = 7'h6F;
            default: op = 7'h0B;
        endcase
        return {r[31:7], op};
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (fetch_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("ready_timeout", {31'b0, fetch_ready}, 32'd1);
    endtask

    task automatic check_outputs(input logic [31:0] e);
        check("instr", instr, e);
        check("type", {26'b0, instruction_type}, {26'b0, ref_type(e)});
        check("imm", immediate, ref_imm(e));
        check("opcode", {25'b0, opcode}, {25'b0, e[6:0]});
        check("rd", {27'b0, rd}, {27'b0, e[11:7]});
        check("rs1", {27'b0, rs1}, {27'b0, e[19:15]});
        check("rs2", {27'b0, rs2}, {27'b0, e[24:20]});
        check("funct3", {29'b0, funct3}, {29'b0, e[14:12]});
        check("funct7", {25'b0, funct7}, {25'b0, e[31:25]});
    endtask

    task automatic do_fetch(input logic [31:0] pc);
        logic        flt;
        logic [31:0] e;
        wait_ready();
        fetch_req = 1'b1;
        fetch_pc  = pc;
        step();
        fetch_req = 1'b0;
        flt = (pc % 4 != 0) || ((pc / 4) >= DEPTH);
        e   = flt ? NOP : model[pc / 4];
        check("fetch_valid", {31'b0, fetch_valid}, 32'd1);
        check("fetch_fault", {31'b0, fetch_fault}, {31'b0, flt});
        check_outputs(e);
        last_instr = e;
    endtask

    task automatic idle_check();
        fetch_req = 1'b0;
        step();
        check("idle_valid", {31'b0, fetch_valid}, 32'd0);
        check("idle_hold", instr, last_instr);
    endtask

    task automatic do_load(input int addr, input int n);
        wait_ready();
        prog_start = 1'b1;
        prog_addr  = AW'(addr);
        step();
        prog_start = 1'b0;
        check("load_prog_ready", {31'b0, prog_ready}, 32'd1);
        check("load_fetch_ready", {31'b0, fetch_ready}, 32'd0);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                prog_valid = 1'b0;
                prog_last  = 1'($urandom_range(0, 1));
                prog_start = 1'b1;
                prog_addr  = AW'($urandom_range(0, DEPTH - 1));
                prog_data  = $urandom();
                step();
                prog_start = 1'b0;
            end
            prog_valid = 1'b1;
            prog_data  = load_buf[i];
            prog_last  = (i == n - 1);
            step();
            model[(addr + i) % DEPTH] = load_buf[i];
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        check("load_done_ready", {31'b0, fetch_ready}, 32'd1);
    endtask

    task automatic count_clear();
        int n;
        n = 0;
        while (fetch_ready !== 1'b1 && n < 100) begin
            n++;
            step();
        end
        check("clear_cycles", n, 32'd16);
        check("init_done", {31'b0, init_done}, 32'd1);
        for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    endtask

    initial begin
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_pc   = '0;
        prog_start = 1'b0;
        prog_addr  = '0;
        prog_valid = 1'b0;
        prog_data  = '0;
        prog_last  = 1'b0;
        dbg_sel    = '0;
        last_instr = NOP;
        repeat (3) step();

        check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_prog_ready", {31'b0, prog_ready}, 32'd0);
        check("rst_init_done", {31'b0, init_done}, 32'd0);
        check("rst_fetch_ready", {31'b0, fetch_ready}, 32'd0);

        rst_n     = 1'b1;
        fetch_req = 1'b1;
        fetch_pc  = 32'd0;
        count_clear();
        fetch_req = 1'b0;
        do_fetch(32'd0);
        check("first_type", {26'b0, instruction_type}, 32'b000010);
        check("first_imm", immediate, 32'd0);
        idle_check();

        load_buf[0] = 32'h03C0_0093;
        load_buf[1] = 32'h0000_2023;
        load_buf[2] = 32'h0000_2103;
        do_load(3, 3);
        do_fetch(32'd12);
        check("addi_rd", {27'b0, rd}, 32'd1);
        check("addi_imm", immediate, 32'd60);
        do_fetch(32'd16);
        do_fetch(32'd20);
        idle_check();

        load_buf[0] = 32'h1234_5037;
        load_buf[1] = 32'h0050_0113;
        do_load(15, 2);
        do_fetch(32'd60);
        do_fetch(32'd0);
        check("wrap_word", instr, 32'h0050_0113);

        do_fetch(32'd2);
        check("misalign_fault", {31'b0, fetch_fault}, 32'd1);
        do_fetch(32'd64);
        check("range_fault", {31'b0, fetch_fault}, 32'd1);

        load_buf[0] = 32'hFC5F_F06F;
        do_load(15, 1);
        do_fetch(32'd60);
        check("jal_type", {26'b0, instruction_type}, 32'b100000);
        check("jal_imm", immediate, 32'hFFFF_FFC4);

        wait_ready();
        fetch_req  = 1'b1;
        fetch_pc   = 32'd12;
        prog_start = 1'b1;
        prog_addr  = AW'(3);
        step();
        fetch_req  = 1'b0;
        prog_start = 1'b0;
        check("same_cycle_valid", {31'b0, fetch_valid}, 32'd1);
        check("same_cycle_old", instr, model[3]);
        check("same_cycle_ready", {31'b0, fetch_ready}, 32'd0);
        prog_valid = 1'b1;
        prog_data  = 32'hDEAD_BEEF;
        step();
        prog_valid = 1'b0;
        rst_n      = 1'b0;
        step();
        rst_n      = 1'b1;
        count_clear();
        for (int i = 0; i < DEPTH; i++) begin
            dbg_sel = AW'(i);
            #1;
            check("dbg_after_reset", dbg_rdata, NOP);
            do_fetch(32'(i * 4));
        end

        for (int it = 0; it < 60; it++) begin
            int          sel;
            logic [31:0] pc;
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                int n;
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) load_buf[i] = rand_instr();
                do_load($urandom_range(0, DEPTH - 1), n);
            end else if (sel == 3) begin
                int k;
                k = $urandom_range(0, DEPTH - 1);
                dbg_sel = AW'(k);
                #1;
                check("dbg_rdata", dbg_rdata, model[k]);
            end else if (sel == 4) begin
                idle_check();
            end else begin
                case ($urandom_range(0, 5))
                    0:       pc = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
                    1:       pc = 32'($urandom_range(DEPTH, 40) * 4);
                    2:       pc = $urandom() & 32'hFFFF_FFFC;
                    default: pc = 32'($urandom_range(0, DEPTH - 1) * 4);
                endcase
                do_fetch(pc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
